dvsd_pdec: RTL and testbench
============================

DVSD_PDEC -- requirements
Module: dvsd_pdec

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 SHALL expose, in order:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  block enable; low forces idle and blocks acceptance.
- in_valid  input  1  code offered this cycle.
- in_ready  output  1  block can accept a code.
- gs_in  input  1  group-select from the encoder side; 1 = code is meaningful.
- code  input  3  binary line index 0..7.
- pulse_len  input  4  drive-phase length in cycles; sampled at accept.
- out  output  8  registered decoded lines.
- busy  output  1  high in DRIVE or GAP.
- done  output  1  one-cycle pulse on normal drive completion.
- nul_cnt  output  8  count of accepted codes with gs_in=0.
- mode  input  1  present only with DVSD_PDEC_THERMO_EN; 0 = one-hot, 1 = thermometer.

Function
REQ-003 SHALL implement FSM states IDLE, DRIVE and GAP.
REQ-004 in_ready SHALL be high only when the state is IDLE and en=1.
REQ-005 Accept SHALL occur when in_valid, in_ready and the rising edge coincide.
REQ-006 Accept with gs_in=1:
- out SHALL be loaded with the decoded code on that edge; first visible out cycle is accept+1.
- the counter SHALL be loaded from pulse_len.
- the FSM SHALL go to DRIVE.
REQ-007 Accept with gs_in=0:
- out SHALL stay 8'h00 and the FSM SHALL stay in IDLE.
- nul_cnt SHALL increment, saturating at 8'hFF.
REQ-008 pulse_len=0 SHALL be treated as 1; out SHALL be high for exactly max(pulse_len,1) cycles.
REQ-009 In DRIVE:
- the counter SHALL decrement each cycle and out SHALL hold its value.
- when the counter reaches 1, the next edge SHALL clear out, enter GAP and pulse done for that one cycle.
REQ-010 GAP SHALL last exactly 1 cycle with out=0, then return to IDLE; min spacing between accepts is max(pulse_len,1)+2 cycles.
REQ-011 en=0 in DRIVE or GAP SHALL, at the next edge, clear out, return to IDLE and suppress done (abort).
REQ-012 in_valid while in_ready=0 SHALL be ignored; nothing is queued.
REQ-013 code, gs_in and pulse_len changes after accept SHALL NOT affect the pulse in progress.
REQ-014 out SHALL never carry X or Z; idle value is 8'h00.
REQ-015 busy SHALL be combinationally (state != IDLE).

Reset
REQ-016 On rst=1 at an edge, the block SHALL apply, overriding all other inputs:
- state = IDLE, out = 8'h00, counter = 0, done = 0, nul_cnt = 0.
REQ-017 Reset mid-DRIVE SHALL abort with no done pulse.
REQ-018 in_ready SHALL be low during the reset cycle, then follow REQ-004.

Configuration
REQ-019 Macro DVSD_PDEC_THERMO_EN SHALL gate the thermometer feature.
REQ-020 With the macro defined:
- the mode port SHALL exist and be sampled at accept.
- mode=1 SHALL set out bits 0..code; code=3 gives 8'h0F.
REQ-021 Without the macro:
- the mode port SHALL be absent.
- decoding SHALL be one-hot only: out = 1 << code.

Structure
REQ-022 Package dvsd_pdec_pkg SHALL hold:
- the state enum (IDLE, DRIVE, GAP).
- CODE_W=3, LINES=8, PLEN_W=4, CNT_W=8.
REQ-023 Combinational sub-module dvsd_dec3to8 SHALL hold the decode function:
- inputs code and mode; output 8-bit lines.
- mode is tied to 0 when the macro is undefined.
- no registers inside.

Verification
REQ-024 Reset, then en=1, accept gs_in=1, code=5, pulse_len=3 -> out=8'h20 for 3 cycles starting at accept+1; done high on the 4th; in_ready high again at accept+5.
REQ-025 Accept gs_in=0, code=7 -> out stays 8'h00, nul_cnt 0->1, in_ready stays high; 300 such accepts -> nul_cnt=8'hFF.
REQ-026 pulse_len=0, code=0 -> out=8'h01 for exactly 1 cycle, then GAP, then IDLE.
REQ-027 code=2, pulse_len=8, en dropped on the 3rd drive cycle -> out=8'h00 next cycle, done never asserted, state IDLE; rst asserted mid-DRIVE -> same outcome, nul_cnt=0.
REQ-028 in_valid held high continuously with codes 0..7 -> each accepted only when in_ready=1, spacing = pulse_len+2, no code lost or doubled in the accept log.
REQ-029 With DVSD_PDEC_THERMO_EN, mode=1, code=6 -> out=8'h7F; with mode=0, code=6 -> out=8'h40.

Source files
------------

// File: rtl/dvsd_pdec_pkg.sv
// Shared types and sizes for the pulse decoder (dvsd_pdec).
// Optional feature macro: DVSD_PDEC_THERMO_EN (thermometer decode mode).
package dvsd_pdec_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;
  localparam int PLEN_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // A requested length of zero still produces a one-cycle pulse.
  function automatic logic [PLEN_W-1:0] eff_len(input logic [PLEN_W-1:0] len);
    if (len == '0) eff_len = PLEN_W'(1);
    else           eff_len = len;
  endfunction

endpackage

// File: rtl/dvsd_pdec_dec.sv
// Combinational 3-to-8 line decoder used by dvsd_pdec.
// mode=0: one-hot (bit code set); mode=1: thermometer (bits 0..code set).
// The top ties mode to 0 unless DVSD_PDEC_THERMO_EN is defined.
module dvsd_dec3to8
  import dvsd_pdec_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              mode,
  output logic [LINES-1:0]  lines
);

  // Per-line select: equality for one-hot, less-or-equal for thermometer.
  always_comb begin
    lines = '0;
    for (int i = 0; i < LINES; i++) begin
      if (mode) lines[i] = (CODE_W'(i) <= code);
      else      lines[i] = (CODE_W'(i) == code);
    end
  end

endmodule

// File: rtl/dvsd_pdec.sv
// Pulse decoder: accepts a 3-bit code and drives the decoded line(s) for
// max(pulse_len,1) cycles, followed by a one-cycle gap.
// Optional feature macro: DVSD_PDEC_THERMO_EN adds the 'mode' port
// (0 = one-hot, 1 = thermometer); without it decoding is one-hot only.
//
// Handshake: a code is accepted on a rising edge where in_valid=1 and
// in_ready=1. in_ready is high only in IDLE with en=1 and rst=0; offers
// made while in_ready=0 are dropped, never queued. Accepts with gs_in=0
// only bump the saturating nul_cnt and leave the FSM in IDLE.
module dvsd_pdec
  import dvsd_pdec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              gs_in,
  input  logic [CODE_W-1:0] code,
  input  logic [PLEN_W-1:0] pulse_len,
  output logic [LINES-1:0]  out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  nul_cnt
`ifdef DVSD_PDEC_THERMO_EN
  ,
  input  logic              mode
`endif
);

  state_e             state_q, state_d;
  logic [LINES-1:0]   out_q, out_d;
  logic [PLEN_W-1:0]  cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   nul_q, nul_d;
  logic               mode_w;
  logic [LINES-1:0]   dec_lines;
  logic               accept;

`ifdef DVSD_PDEC_THERMO_EN
  assign mode_w = mode;
`else
  assign mode_w = 1'b0;
`endif

  dvsd_dec3to8 u_dec (
    .code  (code),
    .mode  (mode_w),
    .lines (dec_lines)
  );

  assign in_ready = (state_q == IDLE) && en && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign out      = out_q;
  assign done     = done_q;
  assign nul_cnt  = nul_q;

  // Next-state: accept in IDLE, count down in DRIVE, one-cycle GAP; en=0 aborts.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    nul_d   = nul_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (gs_in) begin
            out_d   = dec_lines;
            cnt_d   = eff_len(pulse_len);
            state_d = DRIVE;
          end else if (nul_q != '1) begin
            nul_d = nul_q + CNT_W'(1);
          end
        end
      end
      DRIVE: begin
        if (!en) begin
          out_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == PLEN_W'(1)) begin
          out_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - PLEN_W'(1);
        end
      end
      GAP: begin
        out_d   = '0;
        state_d = IDLE;
      end
      default: begin
        out_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      nul_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      nul_q   <= nul_d;
    end
  end

endmodule

// File: tb/tb_dvsd_pdec.sv
// Self-checking bench for dvsd_pdec: directed stimulus pushes expected
// pulses {value, length, done-at-end} into exp_q; a negedge monitor
// measures each pulse on 'out' and compares against the queue head.
module tb_dvsd_pdec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       gs_in = 1'b0;
  logic [2:0] code = '0;
  logic [3:0] pulse_len = '0;
`ifdef DVSD_PDEC_THERMO_EN
  logic       mode = 1'b0;
`endif
  logic       in_ready, busy, done;
  logic [7:0] out, nul_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [13:0] exp_q[$];
  int          cyc = 0;
  bit          mon_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  dvsd_pdec dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gs_in     (gs_in),
    .code      (code),
    .pulse_len (pulse_len),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .nul_cnt   (nul_cnt)
`ifdef DVSD_PDEC_THERMO_EN
    ,
    .mode      (mode)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one code, wait (bounded) for in_ready, accept on the next edge.
  task automatic send(input logic [2:0] c, input logic g, input logic [3:0] pl,
                      input logic [7:0] eo, input logic [4:0] el, input logic ed);
    int n;
    n = 0;
    code = c; gs_in = g; pulse_len = pl; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    check("send_ready", in_ready, 1);
    if (g && in_ready) exp_q.push_back({eo, el, ed});
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick;
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [7:0]  cur_val;
  int          cur_len;
  bit          in_pulse = 1'b0;
  bit          x_seen = 1'b0;
  logic [13:0] e;

  always @(negedge clk) begin
    if (mon_en) begin
      if ($isunknown({out, done, busy, in_ready, nul_cnt})) x_seen = 1'b1;
      if (out != 8'h00) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          cur_val  = out;
          cur_len  = 1;
        end else begin
          cur_len++;
          check("pulse_stable", out, cur_val);
        end
        if (done) check("done_during_drive", done, 0);
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=%0h len=%0d required=none", cur_val, cur_len);
        end else begin
          e = exp_q.pop_front();
          check("pulse_val", cur_val, e[13:6]);
          check("pulse_len", cur_len, e[5:1]);
          check("pulse_done", done, e[0]);
        end
      end else if (done) begin
        check("done_spurious", done, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int last_acc;
    int acc;
    int n;

    // Reset with en already high: in_ready must stay low while rst=1.
    rst = 1'b1; en = 1'b1;
    tick;
    mon_en = 1'b1;
    tick;
    check("reset_out", out, 8'h00);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_nul", nul_cnt, 0);
    check("reset_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);

    // code=5, len=3: 0x20 for 3 cycles, done on 4th, ready at accept+5.
    send(3'd5, 1'b1, 4'd3, 8'h20, 5'd3, 1'b1);
    check("t1_out_c1", out, 8'h20);
    check("t1_busy_c1", busy, 1);
    check("t1_ready_c1", in_ready, 0);
    code = 3'd1; pulse_len = 4'd9; gs_in = 1'b0; in_valid = 1'b1;
    tick;
    tick;
    check("t1_out_c3", out, 8'h20);
    in_valid = 1'b0;
    tick;
    check("t1_out_c4", out, 8'h00);
    check("t1_done_c4", done, 1);
    check("t1_busy_c4", busy, 1);
    check("t1_ready_c4", in_ready, 0);
    tick;
    check("t1_ready_c5", in_ready, 1);
    check("t1_busy_c5", busy, 0);
    check("t1_done_c5", done, 0);
    check("t1_nul_unchanged", nul_cnt, 0);

    // gs_in=0 accepts: out stays 0, nul_cnt saturates at 0xFF.
    send(3'd7, 1'b0, 4'd3, 8'h00, 5'd0, 1'b0);
    check("nul_out", out, 8'h00);
    check("nul_busy", busy, 0);
    check("nul_ready", in_ready, 1);
    check("nul_cnt_1", nul_cnt, 8'h01);
    in_valid = 1'b1;
    repeat (253) tick;
    check("nul_cnt_254", nul_cnt, 8'hFE);
    tick;
    check("nul_cnt_255", nul_cnt, 8'hFF);
    repeat (45) tick;
    check("nul_cnt_sat", nul_cnt, 8'hFF);
    in_valid = 1'b0;

    // pulse_len=0 behaves as 1.
    send(3'd0, 1'b1, 4'd0, 8'h01, 5'd1, 1'b1);
    check("len0_out", out, 8'h01);
    tick;
    check("len0_gap_out", out, 8'h00);
    check("len0_gap_done", done, 1);
    check("len0_gap_busy", busy, 1);
    tick;
    check("len0_idle_busy", busy, 0);
    check("len0_idle_ready", in_ready, 1);

    // en dropped on 3rd drive cycle: abort, no done.
    send(3'd2, 1'b1, 4'd8, 8'h04, 5'd3, 1'b0);
    tick;
    tick;
    check("abort_out_c3", out, 8'h04);
    en = 1'b0;
    tick;
    check("abort_out", out, 8'h00);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick;
    check("abort_done_late", done, 0);
    en = 1'b1;
    #1;
    check("abort_ready", in_ready, 1);

    // rst mid-drive: abort, no done, nul_cnt cleared.
    send(3'd2, 1'b1, 4'd8, 8'h04, 5'd2, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    check("rstmid_out", out, 8'h00);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_nul", nul_cnt, 0);
    check("rstmid_ready", in_ready, 0);
    rst = 1'b0;
    tick;
    check("rstmid_done_late", done, 0);
    check("rstmid_ready_after", in_ready, 1);

    // in_valid held high, codes 0..7, len=2: spacing 4, each accepted once.
    pulse_len = 4'd2; gs_in = 1'b1; in_valid = 1'b1; last_acc = 0;
    for (int k = 0; k < 8; k++) begin
      code = 3'(k);
      exp_q.push_back({8'(1 << k), 5'd2, 1'b1});
      n = 0;
      while (!in_ready && n < 50) begin
        tick;
        n++;
      end
      acc = cyc;
      if (k > 0) check("accept_spacing", acc - last_acc, 4);
      last_acc = acc;
      tick;
    end
    in_valid = 1'b0;
    wait_idle;

`ifdef DVSD_PDEC_THERMO_EN
    mode = 1'b1;
    send(3'd6, 1'b1, 4'd1, 8'h7F, 5'd1, 1'b1);
    wait_idle;
    send(3'd3, 1'b1, 4'd1, 8'h0F, 5'd1, 1'b1);
    wait_idle;
    mode = 1'b0;
    send(3'd6, 1'b1, 4'd1, 8'h40, 5'd1, 1'b1);
    wait_idle;
`endif

    repeat (3) tick;
    check("queue_empty", exp_q.size(), 0);
    check("no_x", x_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
